// File: rtl/avm_pkg.sv
// Shared types and constants for the Avalon-MM burst command master.
package avm_pkg;

   localparam int unsigned ADDR_W = 13;
   localparam int unsigned LEN_W  = 10;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWaitSingle,
      StBurst,
      StFinish
   } avm_state_e;

   typedef logic [1:0] avm_status_t;

   localparam avm_status_t ST_OK       = 2'b00;
   localparam avm_status_t ST_TIMEOUT  = 2'b01;
   localparam avm_status_t ST_UNDERRUN = 2'b10;
   localparam avm_status_t ST_SLVERR   = 2'b11;

   localparam logic [1:0] RESP_SLVERR = 2'b11;

   // A zero-length burst request is issued as a single beat.
   function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
      return (len == '0) ? LEN_W'(1) : len;
   endfunction

endpackage

// File: rtl/avm_beat_counter.sv
// Clear/enable counter with a terminal-match flag; serves as beat counter and watchdog.
module avm_beat_counter
   import avm_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [LEN_W-1:0] i_target,
   output logic             o_match
);

   logic [LEN_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + LEN_W'(1);
      end
   end

   assign o_match = (r_cnt == i_target);

endmodule

// File: rtl/avalon_burst_master.sv
// Host-side Avalon-MM issuer: single read/write and burst write, one-cycle requests.
// Optional watchdog enabled by defining AVM_TIMEOUT_EN.
module avalon_burst_master
   import avm_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 64
)
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic              i_cmd_write,
   input  logic              i_cmd_burst,
   input  logic [ADDR_W-1:0] i_cmd_addr,
   input  logic [LEN_W-1:0]  i_cmd_len,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_wdata_valid,
   output logic              o_wdata_pop,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_rdata_valid,
   output logic              o_done,
   output logic [1:0]        o_status,
   output logic              o_read,
   output logic              o_write,
   output logic              o_beginbursttransfer,
   output logic [LEN_W-1:0]  o_burstcount,
   output logic [ADDR_W-1:0] o_address,
   output logic [DATA_W-1:0] o_writedata,
   input  logic [DATA_W-1:0] i_readdata,
   input  logic              i_readdatavalid,
   input  logic              i_writeresponsevalid,
   input  logic              i_end_wait,
   input  logic [1:0]        i_response
);

   avm_state_e        r_state, w_state_nxt;
   logic              r_write, r_burst, r_underrun, w_underrun_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_len;
   logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
   avm_status_t       r_status, w_status_nxt;
   logic              w_load, w_beat, w_beat_match, w_last_beat, w_to_hit;

   assign w_beat      = (r_state == StBurst) && i_end_wait && (i_response != RESP_SLVERR);
   assign w_last_beat = w_beat && w_beat_match;

   avm_beat_counter u_beat_cnt (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clr    (r_state != StBurst),
      .i_en     (w_beat),
      .i_target (r_len - LEN_W'(1)),
      .o_match  (w_beat_match)
   );

`ifdef AVM_TIMEOUT_EN
   localparam logic [LEN_W-1:0] TO_LAST = LEN_W'(TIMEOUT_CYC - 1);
   logic w_waiting, w_to_reload, w_to_match;

   assign w_waiting   = (r_state == StWaitSingle) || (r_state == StBurst);
   // Any slave strobe restarts the idle window.
   assign w_to_reload = i_end_wait || i_readdatavalid;
   assign w_to_hit    = w_waiting && w_to_match && !w_to_reload;

   avm_beat_counter u_wdog (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clr    (!w_waiting || w_to_reload),
      .i_en     (1'b1),
      .i_target (TO_LAST),
      .o_match  (w_to_match)
   );
`else
   assign w_to_hit = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= StIdle;
         r_write    <= 1'b0;
         r_burst    <= 1'b0;
         r_addr     <= '0;
         r_len      <= '0;
         r_rdata    <= '0;
         r_status   <= ST_OK;
         r_underrun <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_rdata    <= w_rdata_nxt;
         r_status   <= w_status_nxt;
         r_underrun <= w_underrun_nxt;
         if (w_load) begin
            r_write <= i_cmd_write;
            r_burst <= i_cmd_write && i_cmd_burst;
            r_addr  <= i_cmd_addr;
            r_len   <= (i_cmd_write && i_cmd_burst) ? eff_len(i_cmd_len) : LEN_W'(1);
         end
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_status_nxt   = r_status;
      w_underrun_nxt = r_underrun;
      w_rdata_nxt    = r_rdata;
      w_load         = 1'b0;
      o_wdata_pop    = 1'b0;
      case (r_state)
         StIdle: begin
            if (i_cmd_valid) begin
               w_load         = 1'b1;
               w_status_nxt   = ST_OK;
               w_underrun_nxt = 1'b0;
               w_state_nxt    = StIssue;
            end
         end
         StIssue: w_state_nxt = r_burst ? StBurst : StWaitSingle;
         StWaitSingle: begin
            if (i_end_wait && (i_response == RESP_SLVERR)) begin
               w_status_nxt = ST_SLVERR;
               w_state_nxt  = StFinish;
            end else if (!r_write && i_readdatavalid) begin
               w_rdata_nxt = i_readdata;
               w_state_nxt = StFinish;
            end else if (r_write && i_end_wait && i_writeresponsevalid) begin
               o_wdata_pop  = 1'b1;
               w_status_nxt = i_wdata_valid ? ST_OK : ST_UNDERRUN;
               w_state_nxt  = StFinish;
            end else if (w_to_hit) begin
               w_status_nxt = ST_TIMEOUT;
               w_state_nxt  = StFinish;
            end
         end
         StBurst: begin
            if (i_end_wait && (i_response == RESP_SLVERR)) begin
               w_status_nxt = ST_SLVERR;
               w_state_nxt  = StFinish;
            end else if (w_beat) begin
               // An empty FIFO still consumes the beat; it is only flagged.
               o_wdata_pop    = i_wdata_valid;
               w_underrun_nxt = r_underrun || !i_wdata_valid;
               if (w_last_beat) begin
                  w_status_nxt = w_underrun_nxt ? ST_UNDERRUN : ST_OK;
                  w_state_nxt  = StFinish;
               end
            end else if (w_to_hit) begin
               w_status_nxt = ST_TIMEOUT;
               w_state_nxt  = StFinish;
            end
         end
         StFinish: w_state_nxt = StIdle;
         default:  w_state_nxt = StIdle;
      endcase
   end

   assign o_cmd_ready          = (r_state == StIdle) && !i_rst;
   assign o_read               = (r_state == StIssue) && !r_write;
   assign o_write              = (r_state == StIssue) && r_write;
   assign o_beginbursttransfer = (r_state == StIssue) && r_burst;
   assign o_burstcount         = r_len;
   assign o_address            = r_addr;
   assign o_writedata          = i_wdata;
   assign o_rdata              = r_rdata;
   assign o_done               = (r_state == StFinish);
   assign o_status             = r_status;
   assign o_rdata_valid        = o_done && !r_write && (r_status == ST_OK);

endmodule

// File: tb/tb_avalon_burst_master.sv
// Scoreboard bench for avalon_burst_master; timeout case runs when AVM_TIMEOUT_EN is defined.
module tb_avalon_burst_master;
   import avm_pkg::*;

`ifdef AVM_TIMEOUT_EN
   localparam int unsigned TbTimeout = 8;
`else
   localparam int unsigned TbTimeout = 64;
`endif

   logic        clk = 1'b0;
   logic        rst, cmd_valid, cmd_ready, cmd_write, cmd_burst;
   logic [12:0] cmd_addr, address;
   logic [9:0]  cmd_len, burstcount;
   logic [31:0] wdata, rdata, writedata, readdata;
   logic        wdata_valid, wdata_pop, rdata_valid, done;
   logic [1:0]  status, response;
   logic        rd, wr, bbt, readdatavalid, writeresponsevalid, end_wait;

   always #5 clk = ~clk;

   avalon_burst_master #(.TIMEOUT_CYC(TbTimeout)) u_dut (
      .i_clk                (clk),
      .i_rst                (rst),
      .i_cmd_valid          (cmd_valid),
      .o_cmd_ready          (cmd_ready),
      .i_cmd_write          (cmd_write),
      .i_cmd_burst          (cmd_burst),
      .i_cmd_addr           (cmd_addr),
      .i_cmd_len            (cmd_len),
      .i_wdata              (wdata),
      .i_wdata_valid        (wdata_valid),
      .o_wdata_pop          (wdata_pop),
      .o_rdata              (rdata),
      .o_rdata_valid        (rdata_valid),
      .o_done               (done),
      .o_status             (status),
      .o_read               (rd),
      .o_write              (wr),
      .o_beginbursttransfer (bbt),
      .o_burstcount         (burstcount),
      .o_address            (address),
      .o_writedata          (writedata),
      .i_readdata           (readdata),
      .i_readdatavalid      (readdatavalid),
      .i_writeresponsevalid (writeresponsevalid),
      .i_end_wait           (end_wait),
      .i_response           (response)
   );

   typedef struct packed {
      logic [1:0]  st;
      logic        rdv;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] fifo[$];
   logic [31:0] wd_exp[$];

   int unsigned n_vec = 0, n_err = 0;
   int          cyc = 0;
   int          acc_cyc, req_cyc, done_cyc, ew_cyc;
   int          n_req, n_bbt, n_pop, n_done;
   logic [9:0]  bc_seen;
   logic [12:0] addr_seen;
   logic        pop_flag = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic [1:0] s, input logic v, input logic [31:0] d);
      exp_t e;
      e.st    = s;
      e.rdv   = v;
      e.rdata = d;
      return e;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: samples at the falling edge, inputs change 1ns after the rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (cmd_valid && cmd_ready) acc_cyc = cyc;
         if (end_wait) ew_cyc = cyc;
         if (rd || wr) begin
            n_req++;
            req_cyc   = cyc;
            addr_seen = address;
            bc_seen   = burstcount;
         end
         if (bbt) n_bbt++;
         if (wdata_pop) begin
            n_pop++;
            pop_flag = 1'b1;
            if (wd_exp.size() > 0) check("writedata", writedata, wd_exp.pop_front());
            else check("unexpected_pop", 1, 0);
         end
         if (done) begin
            n_done++;
            done_cyc = cyc;
            if (sb.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               check("status", status, e.st);
               check("rdata_valid", rdata_valid, e.rdv);
               if (e.rdv) check("rdata", rdata, e.rdata);
            end
         end else if (rdata_valid) begin
            check("stray_rdata_valid", 1, 0);
         end
      end
   end

   task automatic drive_fifo();
      wdata_valid = (fifo.size() > 0);
      wdata       = wdata_valid ? fifo[0] : 32'h0;
   endtask

   task automatic step();
      logic [31:0] dummy;
      @(posedge clk);
      #1;
      if (pop_flag) begin
         pop_flag = 1'b0;
         if (fifo.size() > 0) dummy = fifo.pop_front();
      end
      drive_fifo();
   endtask

   task automatic load(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         fifo.push_back(base + i);
         wd_exp.push_back(base + i);
      end
      drive_fifo();
   endtask

   task automatic clear_stats();
      n_req = 0; n_bbt = 0; n_pop = 0; n_done = 0;
   endtask

   task automatic issue(input logic w, input logic b, input logic [12:0] a, input logic [9:0] l,
                        input exp_t e);
      int k = 0;
      while (!cmd_ready && k < 20) begin
         step();
         k++;
      end
      check("cmd_ready_before_issue", cmd_ready, 1);
      sb.push_back(e);
      cmd_valid = 1'b1; cmd_write = w; cmd_burst = b; cmd_addr = a; cmd_len = l;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int max);
      int k = 0;
      while (n_done == 0 && k < max) begin
         step();
         k++;
      end
      if (n_done == 0) check("done_timeout", 0, 1);
   endtask

   task automatic beats(input int n);
      for (int i = 0; i < n; i++) begin
         end_wait = 1'b1;
         step();
         end_wait = 1'b0;
         if (i % 2 == 1) step();
      end
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_burst = 1'b0;
      cmd_addr = '0; cmd_len = '0; readdata = '0; readdatavalid = 1'b0;
      writeresponsevalid = 1'b0; end_wait = 1'b0; response = 2'b00;
      drive_fifo();
      step();
      check("reset_cmd_ready", cmd_ready, 0);
      step();
      rst = 1'b0;
      step();
      check("idle_cmd_ready", cmd_ready, 1);
      check("idle_done", done, 0);
      check("idle_status", status, 0);
      check("idle_rdata", rdata, 0);
      check("idle_burstcount", burstcount, 0);
      check("idle_address", address, 0);
      check("idle_strobes", {rd, wr, bbt, wdata_pop}, 0);

      // Single read, zero-wait slave
      clear_stats();
      issue(1'b0, 1'b0, 13'h010, 10'd0, mk(ST_OK, 1'b1, 32'hDEADBEEF));
      step();
      step(); readdatavalid = 1'b1; readdata = 32'hDEADBEEF;
      step(); readdatavalid = 1'b0; readdata = 32'h0;
      wait_done(20);
      check("rd_req_count", n_req, 1);
      check("rd_req_cycle", req_cyc - acc_cyc, 1);
      check("rd_done_cycle", done_cyc - acc_cyc, 4);
      check("rd_address", addr_seen, 13'h010);

      // Single write
      clear_stats();
      load(1, 32'h0000_1234);
      issue(1'b1, 1'b0, 13'h62C, 10'd0, mk(ST_OK, 1'b0, 32'h0));
      step();
      step(); end_wait = 1'b1; writeresponsevalid = 1'b1;
      step(); end_wait = 1'b0; writeresponsevalid = 1'b0;
      wait_done(20);
      check("wr_pop_count", n_pop, 1);
      check("wr_done_cycle", done_cyc - acc_cyc, 4);
      check("wr_address", addr_seen, 13'h62C);
      check("wr_bbt_count", n_bbt, 0);

      // Burst of 4 with full FIFO
      clear_stats();
      load(4, 32'hA000_0000);
      issue(1'b1, 1'b1, 13'h100, 10'd4, mk(ST_OK, 1'b0, 32'h0));
      step();
      beats(4);
      wait_done(20);
      check("b4_bbt_count", n_bbt, 1);
      check("b4_req_count", n_req, 1);
      check("b4_burstcount", bc_seen, 4);
      check("b4_address", addr_seen, 13'h100);
      check("b4_pop_count", n_pop, 4);
      check("b4_done_cycle", done_cyc - ew_cyc, 1);

      // Read answered with slave error
      clear_stats();
      issue(1'b0, 1'b0, 13'h700, 10'd0, mk(ST_SLVERR, 1'b0, 32'h0));
      step();
      step(); end_wait = 1'b1; response = 2'b11;
      step(); end_wait = 1'b0; response = 2'b00;
      wait_done(20);
      check("err_done_count", n_done, 1);

      // Burst of 3 with only 2 words available
      clear_stats();
      load(2, 32'hB000_0000);
      issue(1'b1, 1'b1, 13'h200, 10'd3, mk(ST_UNDERRUN, 1'b0, 32'h0));
      step();
      beats(3);
      wait_done(20);
      check("ur_pop_count", n_pop, 2);

      // Zero length burst behaves as one beat
      clear_stats();
      load(1, 32'hC000_0000);
      issue(1'b1, 1'b1, 13'h300, 10'd0, mk(ST_OK, 1'b0, 32'h0));
      step();
      beats(1);
      wait_done(20);
      check("len0_burstcount", bc_seen, 1);
      check("len0_pop_count", n_pop, 1);

`ifdef AVM_TIMEOUT_EN
      // Silent slave trips the watchdog
      clear_stats();
      issue(1'b0, 1'b0, 13'h040, 10'd0, mk(ST_TIMEOUT, 1'b0, 32'h0));
      wait_done(40);
      check("to_done_cycle", done_cyc - acc_cyc, 10);
`endif

      // Reset in the middle of a burst
      clear_stats();
      load(5, 32'hD000_0000);
      issue(1'b1, 1'b1, 13'h080, 10'd5, mk(ST_OK, 1'b0, 32'h0));
      step();
      beats(2);
      rst = 1'b1;
      sb.delete();
      step();
      check("mid_rst_cmd_ready", cmd_ready, 0);
      check("mid_rst_burstcount", burstcount, 0);
      check("mid_rst_address", address, 0);
      rst = 1'b0;
      fifo.delete();
      wd_exp.delete();
      drive_fifo();
      for (int i = 0; i < 10; i++) step();
      check("mid_rst_pops", n_pop, 2);
      check("mid_rst_no_done", n_done, 0);
      check("post_rst_cmd_ready", cmd_ready, 1);
      check("post_rst_strobes", {rd, wr, bbt}, 0);
      check("scoreboard_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
